// File: rtl/step_cmd_gen.sv
// step_cmd_gen: debounced push-button to single-cycle step strobe (ena) with direction (up).
// Define AUTO_REPEAT_EN to re-fire every REPEAT_CYCLES+1 cycles while the firing button stays held.
module step_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic ena,
    output logic up,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, DEB_UP, DEB_DN, FIRE, HOLD, REL} state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] REP_LAST = 8'(REPEAT_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_CYCLES < 1 || REPEAT_CYCLES > 255) begin : g_bad_param
        $error("step_cmd_gen: DEBOUNCE_CYCLES and REPEAT_CYCLES must be in 1..255");
    end

    state_t state, nxt;
    logic [7:0] cnt, cnt_nxt;
    logic up_nxt, up_m, up_s, dn_m, dn_s;
    logic sole_up, sole_dn, rel, same;

    assign sole_up = up_s & ~dn_s;
    assign sole_dn = dn_s & ~up_s;
    assign rel     = ~up_s & ~dn_s;
    assign same    = up ? sole_up : sole_dn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {up_m, up_s, dn_m, dn_s} <= '0;
            state <= IDLE;
            cnt   <= '0;
            up    <= 1'b0;
        end else begin
            {up_m, up_s, dn_m, dn_s} <= {btn_up, up_m, btn_dn, dn_m};
            state <= nxt;
            cnt   <= cnt_nxt;
            up    <= up_nxt;
        end
    end

    // cnt clears by default; only the counting branches advance it
    always_comb begin
        nxt     = state;
        cnt_nxt = 8'd0;
        up_nxt  = up;
        case (state)
            IDLE:   nxt = sole_up ? DEB_UP : sole_dn ? DEB_DN : IDLE;
            DEB_UP: if (!sole_up) nxt = IDLE;
                    else if (cnt == DEB_LAST) begin nxt = FIRE; up_nxt = 1'b1; end
                    else cnt_nxt = cnt + 8'd1;
            DEB_DN: if (!sole_dn) nxt = IDLE;
                    else if (cnt == DEB_LAST) begin nxt = FIRE; up_nxt = 1'b0; end
                    else cnt_nxt = cnt + 8'd1;
            FIRE:   nxt = HOLD;
`ifdef AUTO_REPEAT_EN
            HOLD:   if (rel) nxt = REL;
                    else if (same) begin
                        if (cnt == REP_LAST) nxt = FIRE;
                        else cnt_nxt = cnt + 8'd1;
                    end
`else
            HOLD:   nxt = rel ? REL : HOLD;
`endif
            REL:    if (!rel) nxt = HOLD;
                    else if (cnt == DEB_LAST) nxt = IDLE;
                    else cnt_nxt = cnt + 8'd1;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ena  = state == FIRE;
        busy = state != IDLE;
    end

`ifndef AUTO_REPEAT_EN
    logic unused_rep;
    assign unused_rep = &{1'b0, same, REP_LAST};
`endif
endmodule
